// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches over an iREN/ihit handshake and holds
// each word for decode until the datapath retires it, then selects the next PC.
module instr_fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        nrst_i,
   input  logic        ihit_i,
   input  logic [31:0] imemload_i,
   output logic        iren_o,
   output logic [31:0] imemaddr_o,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   input  logic        advance_i,
   input  logic [2:0]  pcsrc_i,
   input  logic        branch_taken_i,
   input  logic [15:0] imm_i,
   input  logic [25:0] addr_i,
   input  logic [31:0] jr_target_i,
   input  logic        halt_i,
   output logic [31:0] npc_o,
   output logic        halted_o,
   output logic [31:0] retired_o
);
   typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
   state_t      state_q;
   logic [31:0] pc_q, pc_d, instr_q, retired_q;
   logic        valid_q, halted_q;
   logic [31:0] br_off;
   always_comb begin
      br_off = {{14{imm_i[15]}}, imm_i, 2'b00};
      pc_d   = (pcsrc_i == 3'd1 && branch_taken_i) ? npc_o + br_off :
               (pcsrc_i == 3'd2) ? {npc_o[31:28], addr_i, 2'b00} :
               (pcsrc_i == 3'd3) ? {jr_target_i[31:2], 2'b00} : npc_o;
   end
   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         state_q   <= FETCH;
         pc_q      <= {PC_INIT[31:2], 2'b00};
         instr_q   <= '0;
         valid_q   <= 1'b0;
         retired_q <= '0;
         halted_q  <= 1'b0;
      end else begin
         case (state_q)
            FETCH: if (ihit_i) begin
               instr_q <= imemload_i;
               valid_q <= 1'b1;
               state_q <= EXEC;
            end
            EXEC: if (advance_i) begin
               valid_q   <= 1'b0;
               retired_q <= retired_q + 32'd1;
               if (halt_i) begin
                  state_q  <= HALT;
                  halted_q <= 1'b1;
               end else begin
                  pc_q    <= pc_d;
                  state_q <= FETCH;
               end
            end
            default: ;
         endcase
      end
   end
   assign iren_o        = (state_q == FETCH);
   assign imemaddr_o    = pc_q;
   assign npc_o         = pc_q + 32'd4;
   assign instr_o       = instr_q;
   assign instr_valid_o = valid_q;
   assign halted_o      = halted_q;
   assign retired_o     = retired_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vectors for the fetch/retire loop plus
// hand-written halt and reset sequences.
module tb_instr_fetch_unit;
   logic        clk = 1'b0;
   logic        nrst, ihit, iren, instr_valid, advance, branch_taken, halt, halted;
   logic [31:0] imemload, imemaddr, instr, jr_target, npc, retired;
   logic [2:0]  pcsrc;
   logic [15:0] imm;
   logic [25:0] addr;
   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk_i(clk), .nrst_i(nrst), .ihit_i(ihit), .imemload_i(imemload),
      .iren_o(iren), .imemaddr_o(imemaddr), .instr_o(instr), .instr_valid_o(instr_valid),
      .advance_i(advance), .pcsrc_i(pcsrc), .branch_taken_i(branch_taken), .imm_i(imm),
      .addr_i(addr), .jr_target_i(jr_target), .halt_i(halt), .npc_o(npc),
      .halted_o(halted), .retired_o(retired)
   );

   typedef struct {
      int          wait_n;
      logic [31:0] load;
      logic [2:0]  src;
      logic        bt;
      logic [15:0] imm;
      logic [25:0] addr;
      logic [31:0] jr;
      logic [31:0] exp_pc;
   } vec_t;
   vec_t        v[12];
   int          n_chk = 0, n_fail = 0;
   logic [31:0] pc_m, ret_m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t t);
      for (int k = 0; k < t.wait_n; k++) begin
         tick;
         chk("wait_iren", {31'd0, iren}, 32'd1);
         chk("wait_pc", imemaddr, pc_m);
         chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      end
      ihit = 1'b1; imemload = t.load;
      tick;
      ihit = 1'b0;
      chk("fetch_instr", instr, t.load);
      chk("fetch_valid", {31'd0, instr_valid}, 32'd1);
      chk("exec_iren", {31'd0, iren}, 32'd0);
      chk("exec_npc", npc, pc_m + 32'd4);
      ihit = 1'b1; imemload = ~t.load;
      tick;
      ihit = 1'b0;
      chk("hold_instr", instr, t.load);
      chk("hold_pc", imemaddr, pc_m);
      chk("hold_retired", retired, ret_m);
      pcsrc = t.src; branch_taken = t.bt; imm = t.imm; addr = t.addr; jr_target = t.jr;
      advance = 1'b1;
      tick;
      advance = 1'b0; pcsrc = 3'd0; branch_taken = 1'b0; imm = '0; addr = '0; jr_target = '0;
      pc_m = t.exp_pc;
      ret_m++;
      chk("next_pc", imemaddr, pc_m);
      chk("retired", retired, ret_m);
      chk("retire_valid", {31'd0, instr_valid}, 32'd0);
      chk("retire_iren", {31'd0, iren}, 32'd1);
   endtask

   initial begin
      v[0]  = '{2, 32'h2001_0005, 3'd0, 1'b0, 16'h0000, 26'h0,  32'h0,         32'h0000_0004};
      v[1]  = '{0, 32'h0800_0004, 3'd2, 1'b0, 16'h0000, 26'h4,  32'h0,         32'h0000_0010};
      v[2]  = '{1, 32'h1000_FFFF, 3'd1, 1'b1, 16'hFFFF, 26'h0,  32'h0,         32'h0000_0010};
      v[3]  = '{0, 32'h1000_FFFF, 3'd1, 1'b0, 16'hFFFF, 26'h0,  32'h0,         32'h0000_0014};
      v[4]  = '{0, 32'h0000_0008, 3'd3, 1'b0, 16'h0000, 26'h0,  32'h8000_0020, 32'h8000_0020};
      v[5]  = '{0, 32'h0800_0040, 3'd2, 1'b0, 16'h0000, 26'h40, 32'h0,         32'h8000_0100};
      v[6]  = '{3, 32'h0000_0008, 3'd3, 1'b0, 16'h0000, 26'h0,  32'h0000_0203, 32'h0000_0200};
      v[7]  = '{0, 32'h1234_5678, 3'd5, 1'b1, 16'h0010, 26'h3F, 32'hFFFF_FFFF, 32'h0000_0204};
      v[8]  = '{0, 32'h1000_0003, 3'd1, 1'b1, 16'h0003, 26'h0,  32'h0,         32'h0000_0214};
      v[9]  = '{0, 32'h0000_0008, 3'd3, 1'b0, 16'h0000, 26'h0,  32'hFFFF_FFFF, 32'hFFFF_FFFC};
      v[10] = '{0, 32'h0000_0000, 3'd0, 1'b0, 16'h0000, 26'h0,  32'h0,         32'h0000_0000};
      v[11] = '{0, 32'h0000_0008, 3'd3, 1'b0, 16'h0000, 26'h0,  32'h0000_0040, 32'h0000_0040};
      nrst = 1'b0; ihit = 1'b0; imemload = '0; advance = 1'b0; pcsrc = '0; branch_taken = 1'b0;
      imm = '0; addr = '0; jr_target = '0; halt = 1'b0;
      tick; tick;
      nrst = 1'b1;
      chk("rst_iren", {31'd0, iren}, 32'd1);
      chk("rst_pc", imemaddr, 32'h0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_retired", retired, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      pc_m = 32'h0; ret_m = 32'd0;
      for (int i = 0; i < 12; i++) run_vec(v[i]);
      // reset while waiting on a fetch at 0x40; the coincident ihit must be dropped
      tick;
      chk("pre_rst_pc", imemaddr, 32'h40);
      nrst = 1'b0; ihit = 1'b1; imemload = 32'hDEAD_BEEF;
      tick;
      nrst = 1'b1; ihit = 1'b0;
      chk("mid_rst_pc", imemaddr, 32'h0);
      chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("mid_rst_iren", {31'd0, iren}, 32'd1);
      chk("mid_rst_instr", instr, 32'd0);
      chk("mid_rst_retired", retired, 32'd0);
      ihit = 1'b1; imemload = 32'hFC00_0000;
      tick;
      ihit = 1'b0; halt = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick;
         chk("halt_wait_iren", {31'd0, iren}, 32'd0);
         chk("halt_wait_valid", {31'd0, instr_valid}, 32'd1);
         chk("halt_wait_halted", {31'd0, halted}, 32'd0);
         chk("halt_wait_retired", retired, 32'd0);
      end
      advance = 1'b1;
      tick;
      advance = 1'b0; halt = 1'b0;
      chk("halted", {31'd0, halted}, 32'd1);
      chk("halt_iren", {31'd0, iren}, 32'd0);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_retired", retired, 32'd1);
      chk("halt_pc", imemaddr, 32'h0);
      for (int k = 0; k < 3; k++) begin
         ihit = 1'b1; advance = 1'b1; imemload = 32'h1111_1111; pcsrc = 3'd2; addr = 26'h3FF_FFFF;
         tick;
         chk("halt_stay", {31'd0, halted}, 32'd1);
         chk("halt_stay_iren", {31'd0, iren}, 32'd0);
         chk("halt_stay_retired", retired, 32'd1);
         chk("halt_stay_pc", imemaddr, 32'h0);
         chk("halt_stay_instr", instr, 32'hFC00_0000);
      end
      ihit = 1'b0; advance = 1'b0; pcsrc = '0; addr = '0;
      nrst = 1'b0;
      tick;
      nrst = 1'b1;
      chk("halt_rst_halted", {31'd0, halted}, 32'd0);
      chk("halt_rst_iren", {31'd0, iren}, 32'd1);
      chk("halt_rst_retired", retired, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
